// File: rtl/cpu_fetch_sequencer_if.sv
// Program-memory read port and execute-core issue port of the fetch sequencer.
// master = sequencer side, slave = memory/core side.
interface cpu_fetch_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              exec_valid;
    logic              exec_ready;
    logic [7:0]        exec_instr;
    logic [7:0]        exec_data;

    modport master (
        output mem_req, mem_addr, exec_valid, exec_instr, exec_data,
        input  mem_ack, mem_rdata, exec_ready
    );

    modport slave (
        input  mem_req, mem_addr, exec_valid, exec_instr, exec_data,
        output mem_ack, mem_rdata, exec_ready
    );
endinterface

// File: rtl/cpu_fetch_sequencer.sv
// Fetch sequencer for the 8-bit accumulator core: fetches opcode/operand bytes,
// issues them to the core, and owns the PC including JUMP and HALT.
module cpu_fetch_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    cpu_fetch_sequencer_if.master bus,
    output logic [ADDR_W-1:0]     pc,
    output logic                  halted,
    output logic                  busy,
    output logic [CNT_W-1:0]      retired
);
    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_OP,
        S_FETCH_DATA,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_mem_req;
    logic              r_exec_valid;
    logic [7:0]        r_exec_instr;
    logic [7:0]        r_exec_data;
    logic              r_halted;
    logic              r_busy;
    logic [CNT_W-1:0]  r_retired;

    logic              w_ack;
    logic              w_issue;
    logic [3:0]        w_opcode;
    logic [ADDR_W-1:0] w_pc_inc;

    function automatic logic has_operand(input logic [3:0] op);
        case (op)
            4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: has_operand = 1'b1;
            default:                            has_operand = 1'b0;
        endcase
    endfunction

    // An ack only counts once our own registered request is up.
    assign w_ack    = r_mem_req & bus.mem_ack;
    assign w_issue  = r_exec_valid & bus.exec_ready;
    assign w_opcode = bus.mem_rdata[7:4];
    assign w_pc_inc = r_pc + ADDR_W'(1);

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC_V;
            r_mem_req    <= 1'b0;
            r_exec_valid <= 1'b0;
            r_exec_instr <= 8'h00;
            r_exec_data  <= 8'h00;
            r_halted     <= 1'b0;
            r_busy       <= 1'b0;
            r_retired    <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH_OP;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH_OP: begin
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                    end else if (w_ack) begin
                        r_mem_req    <= 1'b0;
                        r_exec_instr <= bus.mem_rdata;
                        r_pc         <= w_pc_inc;
                        if (w_opcode == 4'hF) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                            r_busy   <= 1'b0;
                        end else if (has_operand(w_opcode)) begin
                            r_state <= S_FETCH_DATA;
                        end else begin
                            r_exec_data  <= 8'h00;
                            r_exec_valid <= 1'b1;
                            r_state      <= S_ISSUE;
                        end
                    end
                end
                S_FETCH_DATA: begin
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                    end else if (w_ack) begin
                        r_mem_req    <= 1'b0;
                        r_exec_data  <= bus.mem_rdata;
                        r_pc         <= w_pc_inc;
                        r_exec_valid <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_exec_valid <= 1'b0;
                        r_retired    <= r_retired + CNT_W'(1);
                        if (r_exec_instr[7:4] == 4'h7) begin
                            r_pc <= ADDR_W'(r_exec_data);
                        end
                        r_state <= S_FETCH_OP;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        r_halted <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_FETCH_OP;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_mem_req    <= 1'b0;
                    r_exec_valid <= 1'b0;
                    r_halted     <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_pc;
    assign bus.exec_valid = r_exec_valid;
    assign bus.exec_instr = r_exec_instr;
    assign bus.exec_data  = r_exec_data;
    assign pc             = r_pc;
    assign halted         = r_halted;
    assign busy           = r_busy;
    assign retired        = r_retired;
endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Scoreboard bench: a reference walk of the program fills expected fetch
// addresses and issued pairs; responders pop and compare as the DUT acts.
module tb_cpu_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pc;
    logic        halted;
    logic        busy;
    logic [15:0] retired;

    cpu_fetch_sequencer_if #(.ADDR_W(8)) bus ();

    cpu_fetch_sequencer #(.ADDR_W(8), .RESET_PC(0), .CNT_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bus     (bus),
        .pc      (pc),
        .halted  (halted),
        .busy    (busy),
        .retired (retired)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:255];
    logic [23:0] sq [$];
    logic [7:0]  fq [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          ack_wait = 0;
    int          ready_hold = 0;
    bit          spurious = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_operand(input logic [3:0] op);
        return (op == 4'h1) || (op == 4'h3) || (op == 4'h4) ||
               (op == 4'h5) || (op == 4'h6) || (op == 4'h7);
    endfunction

    // Walk the program from start_pc; push fetch addresses and issued pairs.
    task automatic build_expect(input logic [7:0] start_pc, input int max_issues,
                                output int n, output logic [7:0] fin_pc);
        logic [7:0] p;
        logic [7:0] op;
        logic [7:0] d;
        p = start_pc;
        n = 0;
        fin_pc = 8'h00;
        for (int s = 0; s < 64; s++) begin
            fq.push_back(p);
            op = mem[p];
            p = p + 8'd1;
            if (op[7:4] == 4'hF) begin
                fin_pc = p;
                break;
            end
            if (ref_operand(op[7:4])) begin
                fq.push_back(p);
                d = mem[p];
                p = p + 8'd1;
            end else begin
                d = 8'h00;
            end
            sq.push_back({op, d, p});
            n++;
            if (op[7:4] == 4'h7) p = d;
            if (n == max_issues) break;
        end
    endtask

    // Program memory responder and fetch-side monitor.
    initial begin
        int         cnt;
        int         len;
        bit         prev_req;
        bit         prev_ack;
        logic [7:0] prev_addr;
        logic [7:0] ea;
        cnt = 0; len = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 8'h00;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                len++;
                if (prev_req && !prev_ack) check_eq("addr_stable", bus.mem_addr, prev_addr);
                if (cnt == ack_wait) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr];
                    cnt = 0;
                    check_eq("req_len", len, ack_wait + 1);
                    if (fq.size() == 0) begin
                        check_eq("fetch_extra", fq.size(), 32'd1);
                    end else begin
                        ea = fq.pop_front();
                        check_eq("fetch_addr", bus.mem_addr, ea);
                    end
                end else begin
                    bus.mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                bus.mem_ack = spurious;
                bus.mem_rdata = 8'hEE;
                cnt = 0;
                len = 0;
            end
            prev_req = (bus.mem_req === 1'b1);
            prev_ack = bus.mem_ack;
            prev_addr = bus.mem_addr;
        end
    end

    // Execute core responder and issue-side scoreboard.
    initial begin
        int          w;
        logic [23:0] e;
        w = 0;
        bus.exec_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.exec_valid === 1'b1) begin
                check_eq("req_in_issue", bus.mem_req, 1'b0);
                if (w == ready_hold) begin
                    bus.exec_ready = 1'b1;
                    w = 0;
                    if (sq.size() == 0) begin
                        check_eq("issue_extra", sq.size(), 32'd1);
                    end else begin
                        e = sq.pop_front();
                        check_eq("issue_instr", bus.exec_instr, e[23:16]);
                        check_eq("issue_data", bus.exec_data, e[15:8]);
                        check_eq("issue_pc", pc, e[7:0]);
                    end
                end else begin
                    bus.exec_ready = 1'b0;
                    w++;
                    if (sq.size() != 0) begin
                        e = sq[0];
                        check_eq("hold_instr", bus.exec_instr, e[23:16]);
                        check_eq("hold_data", bus.exec_data, e[15:8]);
                    end
                end
            end else begin
                bus.exec_ready = spurious;
                w = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ack_wait = 0;
        ready_hold = 0;
        spurious = 1'b0;
        sq.delete();
        fq.delete();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_to_halt(output int cyc);
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (halted) break;
        end
    endtask

    task automatic check_halt(input string tag, input int n_exp, input logic [7:0] pc_exp);
        check_eq({tag, "_halted"}, halted, 1'b1);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_retired"}, retired, n_exp);
        check_eq({tag, "_pc"}, pc, pc_exp);
        check_eq({tag, "_sq_left"}, sq.size(), 32'd0);
        check_eq({tag, "_fq_left"}, fq.size(), 32'd0);
    endtask

    task automatic load_basic();
        mem[0] = 8'h15;
        mem[1] = 8'h42;
        mem[2] = 8'h20;
    endtask

    initial begin
        int         n;
        int         n2;
        int         cyc;
        logic [7:0] fin;
        logic [7:0] fin2;

        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
        repeat (2) @(negedge clk);
        check_eq("rst_mem_req", bus.mem_req, 1'b0);
        check_eq("rst_valid", bus.exec_valid, 1'b0);
        check_eq("rst_instr", bus.exec_instr, 8'h00);
        check_eq("rst_data", bus.exec_data, 8'h00);
        check_eq("rst_pc", pc, 8'h00);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_retired", retired, 16'd0);
        reset = 1'b0;

        // Basic operand + no-operand program, best-case timing, then resume after HALT.
        load_basic();
        build_expect(8'h00, 100, n, fin);
        run_to_halt(cyc);
        check_halt("basic", n, fin);
        check_eq("basic_cycles", cyc, 32'd11);
        build_expect(fin, 100, n2, fin2);
        run_to_halt(cyc);
        check_halt("resume", n + n2, fin2);

        // Slow memory: three-cycle requests with stable address.
        do_reset();
        ack_wait = 2;
        load_basic();
        build_expect(8'h00, 100, n, fin);
        run_to_halt(cyc);
        check_halt("slow", n, fin);

        // JUMP redirect into a HALT.
        do_reset();
        mem[0] = 8'h70;
        mem[1] = 8'h10;
        mem[16] = 8'hFF;
        build_expect(8'h00, 100, n, fin);
        run_to_halt(cyc);
        check_halt("jump", n, fin);

        // Core back-pressure plus spurious ack/ready while idle in those handshakes.
        do_reset();
        ready_hold = 4;
        spurious = 1'b1;
        load_basic();
        build_expect(8'h00, 100, n, fin);
        run_to_halt(cyc);
        check_halt("stall", n, fin);

        // Operand fetch straddling the PC wrap, then reset in the middle of a fetch.
        do_reset();
        mem[0] = 8'h00;
        mem[1] = 8'h70;
        mem[2] = 8'hFF;
        mem[255] = 8'h33;
        build_expect(8'h00, 5, n, fin);
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (retired == 16'(n)) break;
        end
        check_eq("wrap_retired", retired, n);
        check_eq("wrap_sq_left", sq.size(), 32'd0);
        check_eq("wrap_fq_left", fq.size(), 32'd0);
        ack_wait = 8;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_req) break;
        end
        check_eq("abort_req_up", bus.mem_req, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("abort_mem_req", bus.mem_req, 1'b0);
        check_eq("abort_valid", bus.exec_valid, 1'b0);
        check_eq("abort_retired", retired, 16'd0);
        check_eq("abort_pc", pc, 8'h00);
        check_eq("abort_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("idle_mem_req", bus.mem_req, 1'b0);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_halted", halted, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cpu_fetch_sequencer.md
Name: cpu_fetch_sequencer

Overview:
- Sequences the 8-bit accumulator execute core.
- Fetches an opcode byte, plus an operand byte when the opcode needs one, from byte-wide program memory over a req/ack handshake.
- Issues the pair to the core over a valid/ready handshake and owns the program counter, including JUMP redirection and HALT.
- Sits between program memory and the execute core; the core no longer computes its own PC.

Parameters:
- ADDR_W, 8, program memory address width / PC width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  level-sampled run request; leaves IDLE or HALT
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  read address, equals pc while mem_req=1
- mem_ack  in  1  read complete; mem_rdata valid in the same cycle
- mem_rdata  in  8  read data
- exec_valid  out  1  instruction/operand pair available to core
- exec_ready  in  1  core accepts the pair this cycle
- exec_instr  out  8  opcode byte
- exec_data  out  8  operand byte (0x00 when opcode has none)
- pc  out  ADDR_W  address of next byte to fetch
- halted  out  1  high in HALT state
- busy  out  1  high in any state except IDLE and HALT
- retired  out  CNT_W  count of issued instructions, wraps

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, mem_req=0, exec_valid=0, exec_instr=0, exec_data=0, halted=0, retired=0.
- Opcode = instr[7:4]. Operand-bearing opcodes: 0x1 LOAD, 0x3 ADD, 0x4 SUB, 0x5 AND, 0x6 OR, 0x7 JUMP. No operand: everything else. 0xF is HALT.
- States: IDLE, FETCH_OP, FETCH_DATA, ISSUE, HALT.
- IDLE: outputs quiet. start=1 -> FETCH_OP next cycle.
- FETCH_OP:
  - mem_req=1, mem_addr=pc; the request stays asserted with a stable address until mem_ack.
  - On ack: exec_instr<=mem_rdata and pc<=pc+1 (wraps mod 2^ADDR_W).
  - If the opcode is 0xF: go to HALT, exec_valid stays 0, retired is unchanged.
  - Else if the opcode has an operand: go to FETCH_DATA.
  - Else: exec_data<=0 and go to ISSUE.
- FETCH_DATA: same handshake. On ack: exec_data<=mem_rdata, pc<=pc+1, go to ISSUE.
- ISSUE:
  - exec_valid=1. exec_instr and exec_data are held stable until exec_ready.
  - On exec_valid & exec_ready: retired<=retired+1 (wraps).
  - If opcode=0x7: pc<=exec_data (zero-extended/truncated to ADDR_W).
  - Then go to FETCH_OP.
- HALT: halted=1, mem_req=0. start=1 -> FETCH_OP, resuming at the current pc (the byte after the HALT opcode).
- mem_req is registered: it asserts the cycle after the state is entered and drops the cycle after ack. There are no back-to-back requests across a state change.
- Best-case throughput with ack in the first request cycle:
  - Operand instruction: 2 cycles per fetch plus 1 issue cycle.
  - No-operand instruction: 2 + 1 cycles.
- mem_ack while mem_req=0 is ignored. exec_ready while exec_valid=0 is ignored.
- Reset mid-fetch or mid-issue aborts immediately: the request is dropped and the pending instruction is discarded, not counted.
- PC wrap: a fetch at 2^ADDR_W-1 is legal; pc becomes 0. An operand fetch may straddle the wrap.
- start is ignored in FETCH_OP, FETCH_DATA and ISSUE.

Test Plan:
- Reset, mem holds [0x15,0x42,0x20], start=1, ack same cycle, ready=1 -> issues (0x15,0x42) then (0x20,0x00); pc=3; retired=2.
- Memory delays ack 3 cycles on each byte -> mem_req held 3 cycles with stable mem_addr; one issue only; pc increments once per ack.
- Program [0x70,0x10] at 0x00 and 0xFF at 0x10 -> JUMP issued, next fetch address 0x10, then halted=1, busy=0, retired=1, pc=0x11.
- exec_ready low 4 cycles in ISSUE -> exec_valid high and instr/data stable for all 4 cycles; no new mem_req until ready.
- pc preset via program to 0xFF holding 0x33, 0x00 at 0x00 -> operand read from address 0x00 after wrap; exec_data=0x00.
- Assert reset while mem_req=1 mid-wait -> mem_req, exec_valid and retired drop to 0 asynchronously; pc=RESET_PC; state is IDLE until start.
